spi_slave_core: RTL and testbench

SPI mode-0 responder for the FPGA side of a link driven by our 32-bit SPI master core. Receives 32-bit words sent as four byte-frames (each frame = one ss_n low period, 8 bits, LSB first; byte 0 = bits [7:0] first) and simultaneously shifts out a preloaded 32-bit response in the same order. Presents received words and accepts response words on a simple single-cycle strobe interface toward the Avalon wrapper. All logic runs on clk_shift; SPI pins are treated as asynchronous and oversampled.

---
 rtl/spi_slave_core.sv | 187 ++++++++++++++++++
 tb/tb_spi_slave_core.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// SPI mode-0 responder: 32-bit words as four LSB-first byte frames.
// Receives mosi into rx_data and shifts a preloaded response out on miso.
//
// Ports:
//   clk_shift, reset_n      oversampling clock, async active-low reset
//   sclk, ss_n, mosi        SPI pins from the master (asynchronous)
//   miso, miso_oe           SPI response bit and its output enable
//   tx_data, tx_load        response word and 1-cycle capture strobe
//   tx_ready                response hold register is empty
//   rx_data, rx_valid       last received word and its update pulse
//   word_abort              partial word discarded (short frame/timeout)
//   tx_underrun             word started with an empty hold register
//   busy                    word in progress
module spi_slave_core #(
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic        clk_shift,
  input  logic        reset_n,
  input  logic        sclk,
  input  logic        ss_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [31:0] tx_data,
  input  logic        tx_load,
  output logic        tx_ready,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        word_abort,
  output logic        tx_underrun,
  output logic        busy
);

  localparam logic [15:0] IDLE_LAST =
    16'(IDLE_TIMEOUT - 1);

  // [0],[1] synchronizer, [2] history
  logic [2:0]  sclk_sr;
  logic [2:0]  ss_sr;
  logic [1:0]  mosi_sr;

  // Registered edge pulses; mosi_d and
  // ss_sr[2] are aligned with them.
  logic        sclk_rise;
  logic        sclk_fall;
  logic        ss_fall;
  logic        ss_rise;
  logic        mosi_d;
  logic        ss_low;

  logic [1:0]  byte_idx;
  logic [3:0]  bit_cnt;
  logic [7:0]  rx_byte;
  logic [23:0] rx_word;
  logic [31:0] tx_shift;
  logic [31:0] hold;
  logic [31:0] tx_next;
  logic [15:0] idle_cnt;
  logic        word_start;

  assign ss_low     = ~ss_sr[2];
  assign word_start = ss_fall & (byte_idx == 2'd0);
  assign busy       = (byte_idx != 2'd0) | ss_low;

  // Response for a new word: a same-cycle
  // tx_load wins, an empty hold sends zeros.
  always_comb begin
    tx_next = '0;
    if (tx_load) begin
      tx_next = tx_data;
    end else if (!tx_ready) begin
      tx_next = hold;
    end
  end

  always_ff @(posedge clk_shift or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sr   <= '0;
      ss_sr     <= '1;
      mosi_sr   <= '0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      ss_fall   <= 1'b0;
      ss_rise   <= 1'b0;
      mosi_d    <= 1'b0;
    end else begin
      sclk_sr   <= {sclk_sr[1:0], sclk};
      ss_sr     <= {ss_sr[1:0], ss_n};
      mosi_sr   <= {mosi_sr[0], mosi};
      sclk_rise <= sclk_sr[1] & ~sclk_sr[2];
      sclk_fall <= ~sclk_sr[1] & sclk_sr[2];
      ss_fall   <= ~ss_sr[1] & ss_sr[2];
      ss_rise   <= ss_sr[1] & ~ss_sr[2];
      mosi_d    <= mosi_sr[1];
    end
  end

  always_ff @(posedge clk_shift or negedge reset_n) begin
    if (!reset_n) begin
      tx_ready <= 1'b1;
      hold     <= '0;
    end else begin
      if (word_start) begin
        tx_ready <= 1'b1;
      end else if (tx_load) begin
        tx_ready <= 1'b0;
      end
      if (tx_load) begin
        hold <= tx_data;
      end
    end
  end

  always_ff @(posedge clk_shift or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx    <= '0;
      bit_cnt     <= '0;
      rx_byte     <= '0;
      rx_word     <= '0;
      tx_shift    <= '0;
      idle_cnt    <= '0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      word_abort  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      word_abort  <= 1'b0;
      tx_underrun <= 1'b0;
      idle_cnt    <= '0;
      if (ss_fall) begin
        bit_cnt <= '0;
        miso_oe <= 1'b1;
        if (byte_idx == 2'd0) begin
          tx_shift    <= tx_next;
          miso        <= tx_next[0];
          tx_underrun <= ~tx_load & tx_ready;
        end else begin
          miso <= tx_shift[{byte_idx, 3'd0}];
        end
      end else if (ss_rise) begin
        miso_oe <= 1'b0;
        miso    <= 1'b0;
        if (bit_cnt == 4'd8) begin
          if (byte_idx == 2'd3) begin
            rx_data  <= {rx_byte, rx_word};
            rx_valid <= 1'b1;
            byte_idx <= '0;
          end else begin
            case (byte_idx)
              2'd0:    rx_word[7:0]   <= rx_byte;
              2'd1:    rx_word[15:8]  <= rx_byte;
              default: rx_word[23:16] <= rx_byte;
            endcase
            byte_idx <= byte_idx + 2'd1;
          end
        end else begin
          word_abort <= 1'b1;
          byte_idx   <= '0;
        end
      end else if (ss_low) begin
        // Bits past the eighth are ignored.
        if (sclk_rise && bit_cnt < 4'd8) begin
          rx_byte[bit_cnt[2:0]] <= mosi_d;
          bit_cnt <= bit_cnt + 4'd1;
        end else if (sclk_fall) begin
          if (bit_cnt == 4'd8) begin
            miso <= 1'b0;
          end else if (bit_cnt != 4'd0) begin
            miso <= tx_shift[{byte_idx, bit_cnt[2:0]}];
          end
        end
      end else if (byte_idx != 2'd0) begin
        // Master went quiet mid-word.
        if (idle_cnt == IDLE_LAST) begin
          word_abort <= 1'b1;
          byte_idx   <= '0;
        end else begin
          idle_cnt <= idle_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core with a bit-level SPI master model.
// IDLE_TIMEOUT is set to 16 so the timeout path is reached quickly.
module tb_spi_slave_core;

  localparam int TMO = 16;

  logic        clk_shift = 1'b0;
  logic        reset_n   = 1'b0;
  logic        sclk      = 1'b0;
  logic        ss_n      = 1'b1;
  logic        mosi      = 1'b0;
  logic        miso;
  logic        miso_oe;
  logic [31:0] tx_data   = '0;
  logic        tx_load   = 1'b0;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        word_abort;
  logic        tx_underrun;
  logic        busy;

  spi_slave_core #(.IDLE_TIMEOUT(TMO)) dut (
    .clk_shift  (clk_shift),
    .reset_n    (reset_n),
    .sclk       (sclk),
    .ss_n       (ss_n),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .word_abort (word_abort),
    .tx_underrun(tx_underrun),
    .busy       (busy)
  );

  always #5 clk_shift = ~clk_shift;

  int n_pass = 0;
  int n_tot  = 0;
  int rx_cnt = 0;
  int ab_cnt = 0;
  int un_cnt = 0;
  int ovl    = 0;

  always @(negedge clk_shift) begin
    if (rx_valid)    rx_cnt++;
    if (word_abort)  ab_cnt++;
    if (tx_underrun) un_cnt++;
    if (int'(rx_valid) + int'(word_abort) + int'(tx_underrun) > 1)
      ovl++;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_shift);
    #1;
  endtask

  task automatic do_load(input logic [31:0] w);
    tx_data = w;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
    chk("tx_ready_after_load", {31'd0, tx_ready}, 32'd0);
  endtask

  // One byte frame; miso sampled just before each sclk rise.
  task automatic frame(input logic [7:0] b, input int nbits,
                       input int gap, output logic [7:0] got);
    got  = '0;
    ss_n = 1'b0;
    mosi = b[0];
    tick(6);
    for (int i = 0; i < nbits; i++) begin
      if (i < 8) got[i] = miso;
      sclk = 1'b1;
      tick(5);
      sclk = 1'b0;
      mosi = (i + 1 < 8) ? b[i+1] : 1'b1;
      tick(5);
    end
    ss_n = 1'b1;
    tick(gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int nb0,
                           output logic [31:0] got);
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      frame(w[8*k +: 8], (k == 0) ? nb0 : 8, 8, b);
      got[8*k +: 8] = b;
    end
  endtask

  typedef struct {
    logic        load;
    logic [31:0] txw;
    logic [31:0] rxw;
    logic [31:0] exp_miso;
    int          exp_un;
  } vec_t;

  vec_t vt[4];

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    logic [7:0]  b;
    int rx0, ab0, un0, n_ab;

    vt[0] = '{1'b1, 32'hCAFEBABE, 32'h12345678, 32'hCAFEBABE, 0};
    vt[1] = '{1'b1, 32'h13579BDF, 32'h00000001, 32'h13579BDF, 0};
    vt[2] = '{1'b0, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vt[3] = '{1'b1, 32'h80000001, 32'h5AC3A53C, 32'h80000001, 0};

    tick(3);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_rx_data", rx_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    tick(4);

    for (int v = 0; v < 4; v++) begin
      rx0 = rx_cnt;
      un0 = un_cnt;
      if (vt[v].load) do_load(vt[v].txw);
      send_word(vt[v].rxw, 8, got);
      chk($sformatf("v%0d_rx_cnt", v), rx_cnt - rx0, 32'd1);
      chk($sformatf("v%0d_rx_data", v), rx_data, vt[v].rxw);
      chk($sformatf("v%0d_miso", v), got, vt[v].exp_miso);
      chk($sformatf("v%0d_underrun", v), un_cnt - un0, vt[v].exp_un);
      chk($sformatf("v%0d_tx_ready", v), {31'd0, tx_ready}, 32'd1);
    end

    // Byte 2 cut short after 5 clocks.
    rx0 = rx_cnt;
    ab0 = ab_cnt;
    do_load(32'h11223344);
    frame(8'h01, 8, 8, b);
    frame(8'h02, 8, 8, b);
    frame(8'h03, 5, 8, b);
    chk("short_abort", ab_cnt - ab0, 32'd1);
    chk("short_no_rx", rx_cnt - rx0, 32'd0);
    chk("short_rx_held", rx_data, 32'h5AC3A53C);
    chk("short_busy", {31'd0, busy}, 32'd0);
    do_load(32'h0BADF00D);
    send_word(32'hA5A5A5A5, 8, got);
    chk("after_short_rx", rx_data, 32'hA5A5A5A5);
    chk("after_short_miso", got, 32'h0BADF00D);

    // Two bytes then silence: abort 4 input-latency
    // cycles plus TMO cycles after the ss_n pin rises.
    ab0 = ab_cnt;
    frame(8'h0F, 8, 8, b);
    frame(8'h0F, 8, 0, b);
    n_ab = 0;
    for (int c = 1; c <= 60 && n_ab == 0; c++) begin
      @(posedge clk_shift);
      @(negedge clk_shift);
      if (word_abort) n_ab = c;
    end
    chk("tmo_cycles", n_ab, TMO + 4);
    tick(2);
    chk("tmo_abort_cnt", ab_cnt - ab0, 32'd1);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    send_word(32'h0F0F0F0F, 8, got);
    chk("after_tmo_rx", rx_data, 32'h0F0F0F0F);

    // Ten clocks in byte 0; bits past 8 carry 1s.
    rx0 = rx_cnt;
    send_word(32'h3322113C, 10, got);
    chk("extra_rx_cnt", rx_cnt - rx0, 32'd1);
    chk("extra_rx_data", rx_data, 32'h3322113C);

    // Reset in the middle of byte 1.
    do_load(32'h76543210);
    frame(8'hEF, 8, 8, b);
    ss_n = 1'b0;
    mosi = 1'b1;
    tick(6);
    sclk = 1'b1;
    tick(5);
    sclk = 1'b0;
    tick(5);
    chk("mid_miso_oe", {31'd0, miso_oe}, 32'd1);
    reset_n = 1'b0;
    ss_n    = 1'b1;
    @(negedge clk_shift);
    chk("mrst_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("mrst_miso", {31'd0, miso}, 32'd0);
    chk("mrst_rx_data", rx_data, 32'd0);
    chk("mrst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_pulses",
        {29'd0, rx_valid, word_abort, tx_underrun}, 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(4);
    do_load(32'h01020304);
    send_word(32'hDEADBEEF, 8, got);
    chk("post_rst_rx", rx_data, 32'hDEADBEEF);
    chk("post_rst_miso", got, 32'h01020304);

    chk("pulse_overlap", ovl, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
